parity_step_counter: RTL
========================

Name: parity_step_counter

Overview:
- Parametrised successor to the fixed 3-bit odd counter.
- Counts up or down in one of three runtime-selectable sequences: all values, odd only, or even only.
- Adds configurable width, enable, synchronous load, and a registered wrap pulse.
- Used as a general sequence generator for address and phase stepping in the same clock domain.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..32.
- RST_VAL, 1, value of dout at reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = up, 0 = down.
- mode  input  2  00 = all (step 1), 01 = odd (step 2), 10 = even (step 2), 11 = hold.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- dout  output  WIDTH  current count, registered.
- wrap  output  1  one-cycle registered pulse after a step that crossed the range boundary.

Behaviour:
- Reset:
  - reset = 0 forces dout = RST_VAL and wrap = 0 immediately, independent of clk.
  - Release is sampled on the next rising edge.
- Priority on each rising edge: load > (en and mode != 11) > hold.
- Load:
  - mode 01: dout <= load_val with bit0 forced to 1.
  - mode 10: dout <= load_val with bit0 forced to 0.
  - mode 00 or 11: dout <= load_val unchanged.
  - Load never asserts wrap.
- Step, parity already matches mode (or mode 00):
  - dout <= dout ± step, modulo 2^WIDTH.
  - step = 1 in mode 00; step = 2 in modes 01 and 10.
- Snap step, parity mismatches mode 01/10:
  - dout <= dout + 1 (up) or dout - 1 (down), modulo 2^WIDTH.
  - Result always has the mode's parity.
- Wrap sequences (up / down):
  - mode 00: 2^W-1 -> 0 / 0 -> 2^W-1.
  - mode 01: 2^W-1 -> 1 / 1 -> 2^W-1.
  - mode 10: 2^W-2 -> 0 / 0 -> 2^W-2.
  - A snap that crosses the boundary is also a wrap, e.g. even, up, 2^W-1 -> 0.
- wrap:
  - Goes high on the edge that performs a wrapping step; cleared on the next edge unless that step also wraps.
  - Latency 1 cycle, coincident with the wrapped dout value.
- mode 11, or en = 0 without load: dout holds, wrap <= 0.
- mode and up may change on any cycle; the new values take effect on the same edge.
- Arithmetic: internal sum computed at WIDTH+1 bits; the carry/borrow bit is the wrap indication.

Optional Feature:
- Macro: PARITY_STEP_COUNTER_SATURATE_EN.
- Defined:
  - A step that would wrap leaves dout unchanged at its boundary value.
  - wrap pulses for that cycle, flagging a limit hit, and repeats on every enabled step held at the limit.
  - Load and snap behaviour are otherwise unchanged.
- Undefined: modulo wrap exactly as in Behaviour.

Test Plan:
- Default parameters, mode 01, up = 1, en = 1 after reset release -> dout 1,3,5,7,1,3; wrap high only in the cycle dout = 1 after 7.
- mode 10, up = 0, load with load_val = 7 -> dout 6, then 4,2,0,6; wrap high in the cycle dout = 6 after 0.
- mode 00 at dout = 5, up = 1 -> 6,7,0; switch to mode 01 at dout = 0 -> snap to 1, then 3; wrap high only with dout = 0.
- en toggled 1,0,1 and mode 11 for 3 cycles -> dout holds at each; wrap stays 0; load during mode 11 with 4 -> dout = 4.
- Assert reset low mid-count between edges at dout = 5 -> dout = 1 and wrap = 0 before the next edge; counting resumes 3,5 after release.
- With PARITY_STEP_COUNTER_SATURATE_EN, mode 01 up from 5 -> 7,7,7; wrap high on each held cycle. Down from 1 -> dout stays 1.

Source files
------------

// File: rtl/parity_step_counter_if.sv
// parity_step_counter_if
//   Bundles the control and result signals of parity_step_counter.
//   master : drives en, up, mode, load, load_val; observes dout, wrap
//   slave  : the counter itself
interface parity_step_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             up;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] dout;
  logic             wrap;

  modport master (
    output en, up, mode, load, load_val,
    input  dout, wrap
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output dout, wrap
  );
endinterface

// File: rtl/parity_step_counter.sv
// parity_step_counter
//   Up/down sequence generator stepping through all, odd-only or even-only
//   values, with enable, synchronous load and a registered wrap pulse.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset
//     bus   : parity_step_counter_if.slave
//             en, up, mode (00 all / 01 odd / 10 even / 11 hold),
//             load, load_val in; dout, wrap out (both registered)
//   Optional feature macro: PARITY_STEP_COUNTER_SATURATE_EN
//     defined   -> a wrapping step holds dout at its boundary and pulses wrap
//     undefined -> modulo wrap
module parity_step_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned RST_VAL = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  parity_step_counter_if.slave    bus
);

  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_EVEN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             wrap_q, wrap_nxt;
  logic             parity_ok;
  logic [WIDTH:0]   step_amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] load_adj;

  // A step of 2 only when the value already sits on the mode's parity;
  // otherwise a step of 1 snaps it onto that parity.
  always_comb begin
    parity_ok = 1'b1;
    case (bus.mode)
      MODE_ODD:  parity_ok = dout_q[0];
      MODE_EVEN: parity_ok = ~dout_q[0];
      default:   parity_ok = 1'b1;
    endcase
  end

  always_comb begin
    step_amt = (WIDTH+1)'(1);
    if (parity_ok && (bus.mode == MODE_ODD || bus.mode == MODE_EVEN))
      step_amt = (WIDTH+1)'(2);
  end

  // Extra top bit captures carry (up) or borrow (down); either means the
  // step crossed the range boundary.
  always_comb begin
    if (bus.up) sum = {1'b0, dout_q} + step_amt;
    else        sum = {1'b0, dout_q} - step_amt;
  end

  always_comb begin
    load_adj = bus.load_val;
    if (bus.mode == MODE_ODD)  load_adj = {bus.load_val[WIDTH-1:1], 1'b1};
    if (bus.mode == MODE_EVEN) load_adj = {bus.load_val[WIDTH-1:1], 1'b0};
  end

  always_comb begin
    dout_nxt = dout_q;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      dout_nxt = load_adj;
    end else if (bus.en && bus.mode != MODE_HOLD) begin
      wrap_nxt = sum[WIDTH];
`ifdef PARITY_STEP_COUNTER_SATURATE_EN
      if (!sum[WIDTH]) dout_nxt = sum[WIDTH-1:0];
`else
      dout_nxt = sum[WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= WIDTH'(RST_VAL);
      wrap_q <= 1'b0;
    end else begin
      dout_q <= dout_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.dout = dout_q;
  assign bus.wrap = wrap_q;

endmodule
